// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-memory port arbiter.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package mem_arb_pkg;

  // Requester ring length: one read and one write requester per processor.
  localparam int unsigned ARB_REQ_N = 2 * `PROC_COUNT;
  localparam int unsigned ARB_IDX_W = $clog2(ARB_REQ_N);

  typedef logic [$clog2(2*`PROC_COUNT)-1:0] arb_idx_t;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Next requester index around the ring, wrapping to 0.
  function automatic arb_idx_t arb_next(input arb_idx_t idx);
    if (32'(idx) == ARB_REQ_N - 32'd1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin pick: first eligible requester at or after ptr, wrapping.
module mem_port_arbiter_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [ARB_REQ_N-1:0] req,
  input  arb_idx_t             ptr,
  input  logic [ARB_REQ_N-1:0] excl,
  output logic                 found,
  output arb_idx_t             winner
);

  logic [ARB_REQ_N-1:0]   elig;
  logic [ARB_REQ_N-1:0]   hi_mask;
  logic [2*ARB_REQ_N-1:0] dbl;

  // Mask of ring positions at or above the pointer.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(ARB_REQ_N); i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
  end

  // Double-width vector: low half is the pointer-masked copy, high half the wrapped copy.
  always_comb begin
    elig = req & ~excl;
    dbl  = {elig, elig & hi_mask};
  end

  // Priority encode lowest set bit of the double-width vector, folded back onto the ring.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 2 * int'(ARB_REQ_N) - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        found  = 1'b1;
        winner = arb_idx_t'(i % int'(ARB_REQ_N));
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-ported memory among the processor pool.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned PORT_COUNT = `PROC_COUNT,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned IDX_W      = $clog2(PORT_COUNT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PORT_COUNT-1:0] i_req_rd,
  input  logic [PORT_COUNT-1:0] i_req_wr,
  output logic [PORT_COUNT-1:0] o_grant_rd,
  output logic [PORT_COUNT-1:0] o_grant_wr,
  output logic [IDX_W-1:0]      o_sel,
  output logic                  o_sel_wr,
  output logic                  o_sel_valid
);

  arb_state_t           state_q, state_d;
  arb_idx_t             owner_q, owner_d;
  arb_idx_t             ptr_q, ptr_d;
  logic [7:0]           hold_q, hold_d;
  logic [ARB_REQ_N-1:0] req;
  logic [ARB_REQ_N-1:0] excl;
  arb_idx_t             search_ptr;
  logic                 pick_found;
  arb_idx_t             pick_idx;
  logic                 owner_req;
  logic                 hold_max;

  logic [PORT_COUNT-1:0] grant_rd_q, grant_rd_d;
  logic [PORT_COUNT-1:0] grant_wr_q, grant_wr_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic                  sel_wr_q, sel_wr_d;
  logic                  sel_valid_q, sel_valid_d;

  // Interleave requests onto the ring: rd0, wr0, rd1, wr1, ...
  for (genvar p = 0; p < int'(PORT_COUNT); p++) begin : g_ring
    assign req[2*p]   = i_req_rd[p];
    assign req[2*p+1] = i_req_wr[p];
  end

  // While granted, search starts just past the owner and never picks the owner itself.
  assign search_ptr = (state_q == ARB_GRANT) ? arb_next(owner_q) : ptr_q;
  assign excl       = (state_q == ARB_GRANT) ?
                      ({{(ARB_REQ_N-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign owner_req  = req[owner_q];
  assign hold_max   = (hold_q == 8'(MAX_HOLD));

  mem_port_arbiter_rr_pick u_pick (
    .req    (req),
    .ptr    (search_ptr),
    .excl   (excl),
    .found  (pick_found),
    .winner (pick_idx)
  );

  // Next-state: grant, hand over, hold or go idle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          hold_d  = 8'd1;
        end
      end
      ARB_GRANT: begin
        if (!owner_req || hold_max) begin
          if (pick_found) begin
            owner_d = pick_idx;
            ptr_d   = arb_next(owner_q);
            hold_d  = 8'd1;
          end else if (!owner_req) begin
            state_d = ARB_IDLE;
            ptr_d   = arb_next(owner_q);
            hold_d  = 8'd0;
          end else begin
            // Sole requester at its hold limit keeps the grant with a fresh window.
            hold_d = 8'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output next values, derived from the next owner so they register with the state.
  always_comb begin
    grant_rd_d  = '0;
    grant_wr_d  = '0;
    sel_d       = '0;
    sel_wr_d    = 1'b0;
    sel_valid_d = (state_d == ARB_GRANT);
    if (sel_valid_d) begin
      sel_d    = IDX_W'(owner_d[ARB_IDX_W-1:1]);
      sel_wr_d = owner_d[0];
      if (owner_d[0]) grant_wr_d[sel_d] = 1'b1;
      else            grant_rd_d[sel_d] = 1'b1;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      grant_rd_q  <= '0;
      grant_wr_q  <= '0;
      sel_q       <= '0;
      sel_wr_q    <= 1'b0;
      sel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant_rd_q  <= grant_rd_d;
      grant_wr_q  <= grant_wr_d;
      sel_q       <= sel_d;
      sel_wr_q    <= sel_wr_d;
      sel_valid_q <= sel_valid_d;
    end
  end

  assign o_grant_rd  = grant_rd_q;
  assign o_grant_wr  = grant_wr_q;
  assign o_sel       = sel_q;
  assign o_sel_wr    = sel_wr_q;
  assign o_sel_valid = sel_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random-request bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int BOUND = (2 * 4 - 1) * 4 + 1;

  logic       clk;
  logic       rst;
  logic [3:0] req_rd;
  logic [3:0] req_wr;
  logic [3:0] grant_rd;
  logic [3:0] grant_wr;
  logic [1:0] sel;
  logic       sel_wr;
  logic       sel_valid;

  int compared;
  int mismatched;

  mem_port_arbiter #(
    .PORT_COUNT (4),
    .MAX_HOLD   (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_rd    (req_rd),
    .i_req_wr    (req_wr),
    .o_grant_rd  (grant_rd),
    .o_grant_wr  (grant_wr),
    .o_sel       (sel),
    .o_sel_wr    (sel_wr),
    .o_sel_valid (sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inv();
    logic [3:0] er;
    logic [3:0] ew;
    er = (sel_valid && !sel_wr) ? (4'b0001 << sel) : 4'b0000;
    ew = (sel_valid && sel_wr) ? (4'b0001 << sel) : 4'b0000;
    check("inv_onehot", 32'($countones({grant_rd, grant_wr}) <= 1), 32'd1);
    check("inv_rd_sel", 32'(grant_rd), 32'(er));
    check("inv_wr_sel", 32'(grant_wr), 32'(ew));
    check("inv_valid", 32'(sel_valid), 32'(|{grant_rd, grant_wr}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_inv();
  endtask

  task automatic do_reset();
    req_rd = '0;
    req_wr = '0;
    rst    = 1'b1;
    #2;
    rst    = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    logic [7:0] rq;
    int         wait_cnt [8];
    logic       g;
    compared   = 0;
    mismatched = 0;

    // 1: reset with all reads requesting, then release
    rst    = 1'b1;
    req_rd = 4'b1111;
    req_wr = 4'b0000;
    #12;
    check("t1_rst_rd", 32'(grant_rd), 32'h0);
    check("t1_rst_wr", 32'(grant_wr), 32'h0);
    check("t1_rst_valid", 32'(sel_valid), 32'h0);
    rst = 1'b0;
    tick();
    check("t1_grant_rd", 32'(grant_rd), 32'h1);
    check("t1_sel", 32'(sel), 32'h0);
    check("t1_sel_wr", 32'(sel_wr), 32'h0);
    check("t1_valid", 32'(sel_valid), 32'h1);

    // 2: lone wr2 requester keeps the grant through hold reloads
    do_reset();
    req_wr = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t2_grant_wr", 32'(grant_wr), 32'h4);
      check("t2_sel", 32'(sel), 32'h2);
      check("t2_sel_wr", 32'(sel_wr), 32'h1);
    end
    req_wr = 4'b0000;
    tick();
    check("t2_drop_wr", 32'(grant_wr), 32'h0);
    check("t2_drop_valid", 32'(sel_valid), 32'h0);

    // 3: all reads held, rotate every 4 cycles
    do_reset();
    req_rd = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      tick();
      e = 4'b0001 << (((c - 1) / 4) % 4);
      check("t3_grant_rd", 32'(grant_rd), 32'(e));
      check("t3_grant_wr", 32'(grant_wr), 32'h0);
    end

    // 4: read and write of port 1 alternate
    do_reset();
    req_rd = 4'b0010;
    req_wr = 4'b0010;
    for (int c = 1; c <= 16; c++) begin
      tick();
      e = ((((c - 1) / 4) % 2) == 1) ? 4'b0010 : 4'b0000;
      check("t4_grant_wr", 32'(grant_wr), 32'(e));
      check("t4_grant_rd", 32'(grant_rd), 32'(e ^ 4'b0010));
      check("t4_sel", 32'(sel), 32'h1);
      check("t4_sel_wr", 32'(sel_wr), 32'(e[1]));
    end

    // 5: rd0 releases early, wr3 takes over without a bubble
    do_reset();
    req_rd = 4'b0001;
    req_wr = 4'b1000;
    tick();
    check("t5_first_rd", 32'(grant_rd), 32'h1);
    tick();
    check("t5_second_rd", 32'(grant_rd), 32'h1);
    req_rd = 4'b0000;
    tick();
    check("t5_wr3", 32'(grant_wr), 32'h8);
    check("t5_rd_clear", 32'(grant_rd), 32'h0);
    check("t5_sel", 32'(sel), 32'h3);
    check("t5_ptr", 32'(dut.ptr_q), 32'h1);

    // 6: asynchronous reset during a wr2 grant
    do_reset();
    req_wr = 4'b0100;
    tick();
    tick();
    check("t6_pre_wr", 32'(grant_wr), 32'h4);
    rst = 1'b1;
    #1;
    check("t6_async_wr", 32'(grant_wr), 32'h0);
    check("t6_async_valid", 32'(sel_valid), 32'h0);
    req_wr = 4'b0000;
    req_rd = 4'b1000;
    #1;
    rst = 1'b0;
    tick();
    check("t6_rd3", 32'(grant_rd), 32'h8);
    check("t6_sel", 32'(sel), 32'h3);
    check("t6_ptr", 32'(dut.ptr_q), 32'h0);

    // 7: random requests held until granted; every waiter served within the bound
    do_reset();
    rq = '0;
    for (int k = 0; k < 8; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 8; k++) begin
        if (!rq[k] && ($urandom_range(0, 2) == 0)) rq[k] = 1'b1;
      end
      for (int p = 0; p < 4; p++) begin
        req_rd[p] = rq[2*p];
        req_wr[p] = rq[2*p+1];
      end
      tick();
      for (int k = 0; k < 8; k++) begin
        g = (k % 2 == 1) ? grant_wr[k/2] : grant_rd[k/2];
        if (rq[k] && !g) begin
          wait_cnt[k]++;
          check("t7_fair", 32'(wait_cnt[k] <= BOUND), 32'd1);
        end else if (g) begin
          wait_cnt[k] = 0;
          if (rq[k] && ($urandom_range(0, 3) == 0)) rq[k] = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
